// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg
//   Shared types and constants for the unified-memory port arbiter.
//   - arb_state_t : arbiter FSM states
//   - BE_WORD/BE_LO/BE_HI : byte-enable patterns for the 16-bit memory
//   - extend_byte : zero/sign extension of a loaded byte to a full word
package mem_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DATA   = 3'd2,
    ST_RESP_F = 3'd3,
    ST_RESP_D = 3'd4,
    ST_HALTED = 3'd5
  } arb_state_t;

  localparam logic [1:0] BE_WORD = 2'b11;
  localparam logic [1:0] BE_LO   = 2'b01;
  localparam logic [1:0] BE_HI   = 2'b10;

  // Widen a byte to a word; sign=1 replicates bit 7, sign=0 fills with zeros.
  function automatic logic [15:0] extend_byte(input logic [7:0] b, input logic sign);
    logic [7:0] fill;
    fill = sign ? {8{b[7]}} : 8'h00;
    extend_byte = {fill, b};
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align
//   Purely combinational byte-lane logic for the data-memory path.
//   Ports:
//     word_en    in   1 : 1 = word access, 0 = byte access
//     ld_en      in   1 : byte load sign-extend (1) or zero-extend (0)
//     addr_lsb   in   1 : bit 0 of the data byte address
//     store_data in  16 : store data from the pipeline
//     load_word  in  16 : raw word returned by the memory
//     be         out  2 : byte enables for the memory request
//     lane_wdata out 16 : store data steered onto the active lane(s)
//     lane_rdata out 16 : load result after lane select and extension
//     misaligned out  1 : word access to an odd address
module mem_lane_align
  import mem_arb_pkg::*;
(
  input  logic        word_en,
  input  logic        ld_en,
  input  logic        addr_lsb,
  input  logic [15:0] store_data,
  input  logic [15:0] load_word,
  output logic [1:0]  be,
  output logic [15:0] lane_wdata,
  output logic [15:0] lane_rdata,
  output logic        misaligned
);

  // Lane steering for stores and lane select/extension for loads.
  always_comb begin
    be         = BE_WORD;
    lane_wdata = store_data;
    lane_rdata = load_word;
    misaligned = 1'b0;
    if (word_en) begin
      be         = BE_WORD;
      lane_wdata = store_data;
      lane_rdata = load_word;
      misaligned = addr_lsb;
    end else begin
      be = addr_lsb ? BE_HI : BE_LO;
      // Byte stores drive the byte on both lanes; the enables pick the one written.
      lane_wdata = {store_data[7:0], store_data[7:0]};
      if (addr_lsb) begin
        lane_rdata = extend_byte(load_word[15:8], ld_en);
      end else begin
        lane_rdata = extend_byte(load_word[7:0], ld_en);
      end
      misaligned = 1'b0;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-port 16-bit memory between instruction fetch and the
//   data-memory stage. Data accesses win over fetches, every access uses a
//   registered req/ack handshake, and the stall outputs freeze the pipeline
//   while an access is outstanding. After halt no further fetches are issued.
//   Ports:
//     clk, rst                     : clock, synchronous active-high reset
//     if_req/if_addr               : fetch request and word address
//     if_rdata/if_valid/if_stall   : fetch result, completion pulse, stall
//     mem_read/mem_write/word_en/ld_en/d_addr/d_wdata : data request (EX/MEM)
//     halt                         : halt instruction in MEM stage
//     d_rdata/d_valid/d_stall      : data result, completion pulse, stall
//     align_err                    : pulse on word access to odd address
//     mem_req/mem_we/mem_be/mem_addr/mem_wdata : registered memory request
//     mem_rdata/mem_ack            : memory read data and completion
//     halted                       : arbiter is halted
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  output logic              if_stall,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic              word_en,
  input  logic              ld_en,
  input  logic              halt,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_valid,
  output logic              d_stall,
  output logic              align_err,
  output logic              mem_req,
  output logic              mem_we,
  output logic [1:0]        mem_be,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              halted
);

  arb_state_t state;
  arb_state_t next_state;

  logic              dreq;
  logic              grant_fetch;
  logic              grant_data;
  logic              take_misalign;
  logic              fetch_done;
  logic              data_done;
  logic [1:0]        lane_be;
  logic [DATA_W-1:0] lane_wdata;
  logic [DATA_W-1:0] lane_rdata;
  logic              misaligned;

  assign dreq       = mem_read | mem_write;
  assign fetch_done = (state == ST_FETCH) & mem_ack;
  assign data_done  = (state == ST_DATA) & mem_ack;

  assign if_stall = if_req & ~if_valid;
  assign d_stall  = dreq & ~d_valid;

  mem_lane_align u_lane (
    .word_en    (word_en),
    .ld_en      (ld_en),
    .addr_lsb   (d_addr[0]),
    .store_data (d_wdata),
    .load_word  (mem_rdata),
    .be         (lane_be),
    .lane_wdata (lane_wdata),
    .lane_rdata (lane_rdata),
    .misaligned (misaligned)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and grant decode. A misaligned word access skips the memory
  // entirely and goes straight to the data response.
  always_comb begin
    next_state    = state;
    grant_fetch   = 1'b0;
    grant_data    = 1'b0;
    take_misalign = 1'b0;
    case (state)
      ST_IDLE: begin
        if (dreq) begin
          if (misaligned) begin
            next_state    = ST_RESP_D;
            take_misalign = 1'b1;
          end else begin
            next_state = ST_DATA;
            grant_data = 1'b1;
          end
        end else if (halt) begin
          next_state = ST_HALTED;
        end else if (if_req) begin
          next_state  = ST_FETCH;
          grant_fetch = 1'b1;
        end else begin
          next_state = ST_IDLE;
        end
      end
      ST_FETCH: begin
        if (mem_ack) begin
          next_state = ST_RESP_F;
        end else begin
          next_state = ST_FETCH;
        end
      end
      ST_DATA: begin
        if (mem_ack) begin
          next_state = ST_RESP_D;
        end else begin
          next_state = ST_DATA;
        end
      end
      ST_RESP_F: begin
        // The fetch just completed, so only data can be granted here.
        if (dreq) begin
          if (misaligned) begin
            next_state    = ST_RESP_D;
            take_misalign = 1'b1;
          end else begin
            next_state = ST_DATA;
            grant_data = 1'b1;
          end
        end else if (halt) begin
          next_state = ST_HALTED;
        end else begin
          next_state = ST_IDLE;
        end
      end
      ST_RESP_D: begin
        // EX/MEM still holds the finished request, so data is not re-granted.
        if (halt) begin
          next_state = ST_HALTED;
        end else if (if_req) begin
          next_state  = ST_FETCH;
          grant_fetch = 1'b1;
        end else begin
          next_state = ST_IDLE;
        end
      end
      ST_HALTED: begin
        next_state = ST_HALTED;
      end
      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

  // Memory request registers: loaded on grant, held until ack, then released.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_be    <= 2'b00;
      mem_addr  <= {ADDR_W{1'b0}};
      mem_wdata <= {DATA_W{1'b0}};
    end else if (grant_fetch) begin
      mem_req   <= 1'b1;
      mem_we    <= 1'b0;
      mem_be    <= BE_WORD;
      mem_addr  <= if_addr;
      mem_wdata <= {DATA_W{1'b0}};
    end else if (grant_data) begin
      mem_req   <= 1'b1;
      mem_we    <= mem_write;
      mem_be    <= lane_be;
      mem_addr  <= d_addr;
      mem_wdata <= lane_wdata;
    end else if (fetch_done | data_done) begin
      mem_req <= 1'b0;
      mem_we  <= 1'b0;
    end
  end

  // Response registers and one-cycle completion pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      if_rdata  <= {DATA_W{1'b0}};
      if_valid  <= 1'b0;
      d_rdata   <= {DATA_W{1'b0}};
      d_valid   <= 1'b0;
      align_err <= 1'b0;
      halted    <= 1'b0;
    end else begin
      if_valid  <= fetch_done;
      d_valid   <= data_done | take_misalign;
      align_err <= take_misalign;
      halted    <= (next_state == ST_HALTED);
      if (fetch_done) begin
        if_rdata <= mem_rdata;
      end
      if (data_done) begin
        d_rdata <= lane_rdata;
      end else if (take_misalign) begin
        d_rdata <= {DATA_W{1'b0}};
      end
    end
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Controls the single-port unified 16-bit memory shared by instruction fetch and the data-memory stage that reads the EX/MEM pipeline register. It serializes fetch and load/store requests onto one req/ack memory handshake, and gives data accesses priority. It performs byte-lane steering and load extension, and produces the stall signals that freeze the pipeline while an access is outstanding. On `halt` it stops issuing fetches.

## Interface
- `ADDR_W`, 16, memory byte-address width
- `DATA_W`, 16, memory word width; fixed at 16, byte lanes `[7:0]`/`[15:8]`
- `clk  in  1  system clock; all state changes on its rising edge`
- `rst  in  1  reset; synchronous, active-high`
- `if_req  in  1  fetch request; held until `if_valid``
- `if_addr  in  16  fetch address; word-aligned`
- `if_rdata  out  16  fetched instruction; valid only while `if_valid``
- `if_valid  out  1  one-cycle fetch completion pulse`
- `if_stall  out  1  `if_req & ~if_valid`, combinational`
- `mem_read  in  1  load request, from EX/MEM`
- `mem_write  in  1  store request, from EX/MEM`
- `word_en  in  1  1 = word access, 0 = byte access`
- `ld_en  in  1  byte load: 1 = sign-extend, 0 = zero-extend`
- `halt  in  1  halt instruction has reached the MEM stage`
- `d_addr  in  16  data address (`alu_out_reg`)`
- `d_wdata  in  16  store data (`reg_out_reg`)`
- `d_rdata  out  16  load result; valid only while `d_valid``
- `d_valid  out  1  one-cycle data completion pulse; also pulses for stores`
- `d_stall  out  1  `(mem_read|mem_write) & ~d_valid`, combinational`
- `align_err  out  1  one-cycle pulse: word access to an odd address`
- `mem_req  out  1  memory request, registered`
- `mem_we  out  1  write enable, registered`
- `mem_be  out  2  byte enables, registered`
- `mem_addr  out  16  address, registered`
- `mem_wdata  out  16  write data, registered`
- `mem_rdata  in  16  read data; sampled when `mem_ack``
- `mem_ack  in  1  memory completion; any wait count, including 0`
- `halted  out  1  arbiter is in the HALTED state`

## Operation
- States are IDLE, FETCH, DATA, RESP_F, RESP_D and HALTED.
- Data request pending is `dreq = mem_read | mem_write`. If both `mem_read` and `mem_write` are high, the access is treated as a write.
- IDLE:
  - `dreq` → DATA.
  - Otherwise, `halt` → HALTED.
  - Otherwise, `if_req` → FETCH.
  - Data always wins when both requesters are pending.
- Entering FETCH or DATA latches `mem_addr`, `mem_we`, `mem_be` and `mem_wdata`, and sets `mem_req=1`. These stay stable until `mem_ack`.
- FETCH + `mem_ack` → RESP_F, with `if_rdata` registered.
- DATA + `mem_ack` → RESP_D, with the lane-processed `d_rdata` registered.
- RESP_F pulses `if_valid`.
  - Next state: `dreq` → DATA, else `halt` → HALTED, else IDLE.
  - Fetch is not re-granted from RESP_F.
- RESP_D pulses `d_valid`.
  - Next state: `halt` → HALTED, else `if_req` → FETCH, else IDLE.
  - Data is not re-granted from RESP_D, because the EX/MEM register still holds the completed request.
- HALTED: `mem_req=0`, `halted=1`, `if_stall` follows `if_req`. Only `rst` leaves this state.
- Lane rules:
  - Word access: `mem_be=2'b11`, `mem_wdata=d_wdata`.
  - Byte access: `mem_be = d_addr[0] ? 2'b10 : 2'b01`, `mem_wdata={d_wdata[7:0],d_wdata[7:0]}`.
  - Byte load: the selected lane is extended according to `ld_en`.
  - Fetch: `mem_be=2'b11`, `mem_we=0`.
- Misaligned word access (`word_en=1`, `d_addr[0]=1`) in IDLE or RESP_F:
  - No memory request is issued.
  - Next state is RESP_D, with `align_err=1`, `d_valid=1` and `d_rdata=0` in that cycle.
- `mem_ack` outside FETCH/DATA is ignored.

## Timing
- Reset values: state=IDLE; `mem_req`, `mem_we`, `if_valid`, `d_valid`, `align_err` and `halted` are 0; `mem_be=0`, `mem_addr=0`, `mem_wdata=0`, `if_rdata=0`, `d_rdata=0`.
- Latency with a zero-wait memory:
  - cycle 0: request sampled in IDLE.
  - cycle 1: `mem_req=1` and `mem_ack=1`.
  - cycle 2: `valid` pulse.
  - Each memory wait cycle adds one cycle.
- Back-to-back data then fetch occupies 4 cycles with no idle gap.
- `rst` asserted mid-transaction forces IDLE with `mem_req=0` at the next edge. A late `mem_ack` is then dropped.

## Structure
- Package `mem_arb_pkg`:
  - state enum.
  - `BE_WORD`, `BE_LO`, `BE_HI` constants.
- One combinational sub-module, `mem_lane_align`:
  - store lane steering and `mem_be` generation.
  - load byte select and extension.
  - misalignment detect.
- The FSM and registers live in the top-level module.

## Test plan
- Fetch only, `if_addr=16'h0010`, memory returns `16'h1234` with 0 waits → `mem_req` high in cycle 1, `if_valid` with `16'h1234` in cycle 2, `if_stall` high in cycles 0–1.
- Simultaneous `if_req` and `mem_read` word load at `16'h0020` → data first (`d_valid` cycle 2), fetch `mem_req` cycle 3, `if_valid` cycle 4.
- Byte store, `d_addr=16'h0031`, `d_wdata=16'h00A5`, 2 wait states → `mem_be=2'b10`, `mem_wdata=16'hA5A5` held 3 cycles, `d_valid` in cycle 4.
- Byte load at an odd address, memory returns `16'h8F00`:
  - `ld_en=1` → `d_rdata=16'hFF8F`.
  - `ld_en=0` → `d_rdata=16'h008F`.
- Word load at `16'h0041` → no `mem_req`, `align_err` and `d_valid` high the next cycle, `d_rdata=0`.
- `halt` while a fetch is outstanding → fetch completes, then HALTED with no further `mem_req`. `rst` returns the arbiter to IDLE, with all outputs at their reset values.
